// File: rtl/hc595_serial_driver.sv
// Serialises a parallel word onto a (chain of) 74HC595 shift registers:
// SER/SRCLK bit shifting, RCLK latch pulse, clear sequence and OE_n drive.
module hc595_serial_driver #(
   parameter int WIDTH     = 8,
   parameter int CLK_DIV   = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear_req,
   input  logic             out_en,
   output logic             ser_out,
   output logic             srclk_out,
   output logic             rclk_out,
   output logic             srclr_n_out,
   output logic             oe_n_out,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, SHIFT_LO, SHIFT_HI, LATCH_LO, LATCH_HI, CLR_LO, CLR_LATCH
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [BIT_W-1:0] bit_cnt, bit_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic             ser_nxt;
   logic             done_nxt;
   logic             phase_end;

   function automatic logic first_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? (v << 1) : (v >> 1);
   endfunction

   assign in_ready  = ena & (state == IDLE) & ~clear_req;
   assign phase_end = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      ser_nxt   = ser_out;
      done_nxt  = 1'b0;
      if (state == IDLE) begin
         // clear wins over a simultaneous word
         if (clear_req) begin
            state_nxt = CLR_LO;
            div_nxt   = '0;
         end else if (in_valid) begin
            state_nxt = SHIFT_LO;
            div_nxt   = '0;
            bit_nxt   = '0;
            shreg_nxt = in_data;
            ser_nxt   = first_bit(in_data);
         end
      end else if (!phase_end) begin
         div_nxt = div_cnt + DIV_W'(1);
      end else begin
         div_nxt = '0;
         case (state)
            SHIFT_LO: state_nxt = SHIFT_HI;
            SHIFT_HI: begin
               if (bit_cnt == BIT_LAST) begin
                  state_nxt = LATCH_LO;
               end else begin
                  state_nxt = SHIFT_LO;
                  bit_nxt   = bit_cnt + BIT_W'(1);
                  shreg_nxt = advance(shreg);
                  ser_nxt   = first_bit(advance(shreg));
               end
            end
            LATCH_LO:  state_nxt = LATCH_HI;
            LATCH_HI: begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            CLR_LO:    state_nxt = CLR_LATCH;
            CLR_LATCH: begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            default:   state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         ser_out     <= 1'b0;
         srclk_out   <= 1'b0;
         rclk_out    <= 1'b0;
         srclr_n_out <= 1'b1;
         oe_n_out    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         oe_n_out <= ~out_en;
         if (ena) begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            bit_cnt     <= bit_nxt;
            ser_out     <= ser_nxt;
            srclk_out   <= (state_nxt == SHIFT_HI);
            rclk_out    <= (state_nxt == LATCH_HI) || (state_nxt == CLR_LATCH);
            srclr_n_out <= (state_nxt != CLR_LO);
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
         end else begin
            // paused: keep the pulse one cycle wide
            done <= 1'b0;
         end
      end
   end

   // shift data is not reset; a mid-frame reset leaves the partial word in place
   always_ff @(posedge clk) begin
      if (ena) shreg <= shreg_nxt;
   end

endmodule
